mips_mc_controller: RTL and testbench
=====================================

# mips_mc_controller

Parametrised multicycle control unit for the MIPS core, driving the datapath and the ALU-control decoder. Generalises the existing controller in three ways: datapath width is a parameter with instruction fetch in 32/WIDTH beats, memory accesses use a ready handshake so memory may insert wait states, and the PC-enable logic (branch and zero gating) is absorbed into this block. It also reports per-instruction retirement and illegal opcodes.

## Interface
- WIDTH, 8: datapath/memory width; legal values 8, 16, 32. BEATS = 32/WIDTH.
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- op  in  6  instr[31:26] from the datapath instruction register
- zero  in  1  ALU zero flag
- memready  in  1  memory has completed the current read/write this cycle
- memread  out  1  memory read request
- memwrite  out  1  memory write request
- alusrca  out  1  0 = PC, 1 = register A
- alusrcb  out  2  00 = B, 01 = constant WIDTH/8, 10 = imm, 11 = imm<<2
- aluop  out  2  00 add, 01 sub, 10 funct-decoded
- pcsource  out  2  00 ALU result, 01 ALUOut, 10 jump target
- iord  out  1  0 = PC address, 1 = ALUOut address
- memtoreg, regwrite, regdst  out  1 each  register-file write controls
- irwrite  out  BEATS  one-hot instruction-register beat enable
- pcen  out  1  pcwrite OR (branch AND zero)
- instr_done  out  1  one-cycle pulse in the final cycle of every instruction
- illegal  out  1  one-cycle pulse when DECODE sees an unsupported opcode

## Operation
- Opcodes: RTYPE 000000, LW 100011, SW 101011, BEQ 000100, J 000010, ADDI 001000 (ADDI only with the macro below).
- States and transitions:
  - FETCH(beat k, k=0..BEATS-1): memread=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsource=00. irwrite[k] and pcwrite asserted only in the cycle memready=1. On memready: k+1, or DECODE after beat BEATS-1. Without memready: hold, no irwrite, no pcen.
  - DECODE: alusrca=0, alusrcb=11, aluop=00. Next: LW/SW→MEMADR, RTYPE→RTEX, BEQ→BEQEX, J→JEX, ADDI→ADDIEX, else→FETCH beat 0 with illegal=1 and instr_done=1.
  - MEMADR: alusrca=1, alusrcb=10, aluop=00 → LWRD (LW) or SWWR (SW).
  - LWRD: memread=1, iord=1; hold until memready → LWWR.
  - LWWR: regwrite=1, memtoreg=1, regdst=0, instr_done=1 → FETCH.
  - SWWR: memwrite=1, iord=1; hold until memready; instr_done=1 in the memready cycle → FETCH.
  - RTEX: alusrca=1, alusrcb=00, aluop=10 → RTWR.
  - RTWR: regwrite=1, regdst=1, memtoreg=0, instr_done=1 → FETCH.
  - BEQEX: alusrca=1, alusrcb=00, aluop=01, pcsource=01, branch=1, instr_done=1 → FETCH.
  - JEX: pcsource=10, pcwrite=1, instr_done=1 → FETCH.
  - ADDIEX: alusrca=1, alusrcb=10, aluop=00 → ADDIWR. ADDIWR: regwrite=1, regdst=0, memtoreg=0, instr_done=1 → FETCH.
- Unlisted outputs are 0 in every state. memread and memwrite are never both 1.
- op is sampled only in DECODE and MEMADR. Changes in other states are ignored.

## Timing
- Outputs are Moore-decoded from state, except irwrite, pcen, and the SWWR instr_done, which are qualified by memready or zero in the same cycle.
- While rst=1, every output is 0. The first rising edge with rst=0 sees FETCH beat 0.
- Reset mid-instruction, including during a memory wait: the next edge returns to FETCH beat 0, and the beat counter clears.
- Zero-wait latencies (cycles, memready tied high): fetch+decode BEATS+1. LW BEATS+4, SW BEATS+3, RTYPE BEATS+3, ADDI BEATS+3, BEQ BEATS+2, J BEATS+2, illegal BEATS+1.
- Each memory wait cycle adds exactly one cycle. Request signals stay asserted and stable until the memready cycle.

## Configuration
- MIPS_ADDI_EN defined: the ADDI opcode decodes to ADDIEX/ADDIWR.
- MIPS_ADDI_EN undefined: ADDIEX/ADDIWR are absent, and 001000 is illegal (illegal pulse, return to FETCH).

## Test plan
- WIDTH=8, memready=1, reset then R-type (op=000000): irwrite = 0001, 0010, 0100, 1000 on cycles 1–4. DECODE at cycle 5, RTWR with regwrite=1, regdst=1 and instr_done=1 at cycle 7. pcen=1 on exactly 4 cycles.
- WIDTH=8, LW with memready low 2 cycles in beat 1 and 3 cycles in LWRD: irwrite[1] pulses once, after the wait. memread and iord=1 hold through LWRD. Total 8+5=13 cycles.
- BEQ with zero=1, then BEQ with zero=0: pcen=1 with pcsource=01 in BEQEX only when zero=1. In both cases instr_done=1 in BEQEX.
- WIDTH=32 (BEATS=1) SW with memready=1: FETCH, DECODE, MEMADR, SWWR, in 4 cycles. memwrite=1 only in SWWR, and irwrite is 1 bit.
- rst asserted during LWRD wait: all outputs go to 0 while rst=1. After release, memread=1, iord=0, and irwrite[0] is set on the first memready.
- op=001000 with and without MIPS_ADDI_EN: with the macro, regwrite=1 in ADDIWR at cycle BEATS+3. Without it, illegal=1 in DECODE and no regwrite.

Source files
------------

// File: rtl/mips_mc_controller.sv
// mips_mc_controller: multicycle MIPS control unit.
// Fetches a 32-bit instruction in 32/WIDTH memory beats, decodes the opcode and
// sequences the datapath through execute/memory/writeback. Memory accesses wait
// for memready. The PC-enable gating (pcwrite, branch and zero) is produced here.
// Optional feature macro: MIPS_ADDI_EN adds ADDI (opcode 001000) execution states;
// without it, 001000 is reported as illegal.
module mips_mc_controller #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5:0]            op,
    input  logic                  zero,
    input  logic                  memready,
    output logic                  memread,
    output logic                  memwrite,
    output logic                  alusrca,
    output logic [1:0]            alusrcb,
    output logic [1:0]            aluop,
    output logic [1:0]            pcsource,
    output logic                  iord,
    output logic                  memtoreg,
    output logic                  regwrite,
    output logic                  regdst,
    output logic [32/WIDTH-1:0]   irwrite,
    output logic                  pcen,
    output logic                  instr_done,
    output logic                  illegal
);

    localparam int BEATS = 32 / WIDTH;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MIPS_ADDI_EN
    localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_LWRD,
        S_LWWR,
        S_SWWR,
        S_RTEX,
        S_RTWR,
        S_BEQEX,
        S_JEX
`ifdef MIPS_ADDI_EN
        , S_ADDIEX,
        S_ADDIWR
`endif
    } state_t;

    // Control word decoded from a state; fetch/swwr/decode flags let the
    // memready-, zero- and op-qualified outputs be finished combinationally.
    typedef struct packed {
        logic       memread;
        logic       memwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsource;
        logic       iord;
        logic       memtoreg;
        logic       regwrite;
        logic       regdst;
        logic       pcwrite;
        logic       branch;
        logic       done;
        logic       fetch;
        logic       swwr;
        logic       decode;
    } ctrl_t;

    function automatic logic op_legal(input logic [5:0] code);
        logic ok;
        ok = (code == OP_RTYPE) || (code == OP_LW) || (code == OP_SW) ||
             (code == OP_BEQ)   || (code == OP_J);
`ifdef MIPS_ADDI_EN
        ok = ok || (code == OP_ADDI);
`endif
        return ok;
    endfunction

    function automatic state_t next_state(input state_t s, input logic last_beat,
                                          input logic [5:0] code, input logic ready);
        state_t n;
        n = s;
        case (s)
            S_FETCH:  if (ready && last_beat) n = S_DECODE;
            S_DECODE: begin
                if (code == OP_LW || code == OP_SW) n = S_MEMADR;
                else if (code == OP_RTYPE)          n = S_RTEX;
                else if (code == OP_BEQ)            n = S_BEQEX;
                else if (code == OP_J)              n = S_JEX;
`ifdef MIPS_ADDI_EN
                else if (code == OP_ADDI)           n = S_ADDIEX;
`endif
                else                                n = S_FETCH;
            end
            S_MEMADR: n = (code == OP_LW) ? S_LWRD : S_SWWR;
            S_LWRD:   if (ready) n = S_LWWR;
            S_SWWR:   if (ready) n = S_FETCH;
            S_RTEX:   n = S_RTWR;
`ifdef MIPS_ADDI_EN
            S_ADDIEX: n = S_ADDIWR;
`endif
            // Single-cycle final states (and any unused encoding) return to fetch.
            default:  n = S_FETCH;
        endcase
        return n;
    endfunction

    function automatic ctrl_t decode_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH:  begin c.memread = 1'b1; c.alusrcb = 2'b01; c.fetch = 1'b1; end
            S_DECODE: begin c.alusrcb = 2'b11; c.decode = 1'b1; end
            S_MEMADR: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            S_LWRD:   begin c.memread = 1'b1; c.iord = 1'b1; end
            S_LWWR:   begin c.regwrite = 1'b1; c.memtoreg = 1'b1; c.done = 1'b1; end
            S_SWWR:   begin c.memwrite = 1'b1; c.iord = 1'b1; c.swwr = 1'b1; end
            S_RTEX:   begin c.alusrca = 1'b1; c.aluop = 2'b10; end
            S_RTWR:   begin c.regwrite = 1'b1; c.regdst = 1'b1; c.done = 1'b1; end
            S_BEQEX:  begin
                c.alusrca  = 1'b1; c.aluop = 2'b01; c.pcsource = 2'b01;
                c.branch   = 1'b1; c.done  = 1'b1;
            end
            S_JEX:    begin c.pcsource = 2'b10; c.pcwrite = 1'b1; c.done = 1'b1; end
`ifdef MIPS_ADDI_EN
            S_ADDIEX: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            S_ADDIWR: begin c.regwrite = 1'b1; c.done = 1'b1; end
`endif
            default:  c = '0;
        endcase
        return c;
    endfunction

    state_t         state;
    state_t         state_next;
    ctrl_t          ctrl;
    logic [BW-1:0]  beat;
    logic           last_beat;
    logic           run;

    assign last_beat  = (beat == BW'(BEATS - 1));
    assign state_next = next_state(state, last_beat, op, memready);
    assign run        = ~rst;

    // State, fetch beat counter and the control word for the entered state.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state <= S_FETCH;
            beat  <= '0;
            ctrl  <= decode_ctrl(S_FETCH);
        end else begin
            state <= state_next;
            ctrl  <= decode_ctrl(state_next);
            if (ctrl.fetch && memready)
                beat <= last_beat ? '0 : beat + 1'b1;
        end
    end

    // Registered control word, forced to zero while reset is held.
    assign memread  = run & ctrl.memread;
    assign memwrite = run & ctrl.memwrite;
    assign alusrca  = run & ctrl.alusrca;
    assign alusrcb  = {2{run}} & ctrl.alusrcb;
    assign aluop    = {2{run}} & ctrl.aluop;
    assign pcsource = {2{run}} & ctrl.pcsource;
    assign iord     = run & ctrl.iord;
    assign memtoreg = run & ctrl.memtoreg;
    assign regwrite = run & ctrl.regwrite;
    assign regdst   = run & ctrl.regdst;

    // A fetch beat only lands (IR write, PC advance) in its memready cycle.
    assign irwrite = (run && ctrl.fetch && memready) ? (BEATS'(1) << beat) : '0;
    assign pcen    = run & (ctrl.pcwrite | (ctrl.fetch & memready) | (ctrl.branch & zero));

    // Illegal opcodes end the instruction in DECODE; stores end on memready.
    assign illegal    = run & ctrl.decode & ~op_legal(op);
    assign instr_done = run & (ctrl.done | (ctrl.swwr & memready) | (ctrl.decode & ~op_legal(op)));

endmodule

// File: tb/tb_mips_mc_controller.sv
// tb_mips_mc_controller: randomized self-checking bench for mips_mc_controller.
// A WIDTH=8 and a WIDTH=32 instance share op/zero/memready; each is exercised
// while the other is held in reset. Expected outputs come from per-instruction
// phase scripts built from the opcode rules, with random waits and random
// op/zero/memready in cycles where they must be ignored.
module tb_mips_mc_controller;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    typedef struct packed {
        logic       memread;
        logic       memwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsource;
        logic       iord;
        logic       memtoreg;
        logic       regwrite;
        logic       regdst;
        logic [3:0] irwrite;
        logic       pcen;
        logic       instr_done;
        logic       illegal;
    } out_t;

    logic       clk = 1'b0;
    logic       rst8, rst32;
    logic [5:0] op;
    logic       zero, memready;

    logic       d8_memread, d8_memwrite, d8_alusrca, d8_iord, d8_memtoreg, d8_regwrite, d8_regdst;
    logic [1:0] d8_alusrcb, d8_aluop, d8_pcsource;
    logic [3:0] d8_irwrite;
    logic       d8_pcen, d8_instr_done, d8_illegal;

    logic       d32_memread, d32_memwrite, d32_alusrca, d32_iord, d32_memtoreg, d32_regwrite, d32_regdst;
    logic [1:0] d32_alusrcb, d32_aluop, d32_pcsource;
    logic [0:0] d32_irwrite;
    logic       d32_pcen, d32_instr_done, d32_illegal;

    out_t o8, o32;

    mips_mc_controller #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst8), .op(op), .zero(zero), .memready(memready),
        .memread(d8_memread), .memwrite(d8_memwrite), .alusrca(d8_alusrca),
        .alusrcb(d8_alusrcb), .aluop(d8_aluop), .pcsource(d8_pcsource),
        .iord(d8_iord), .memtoreg(d8_memtoreg), .regwrite(d8_regwrite),
        .regdst(d8_regdst), .irwrite(d8_irwrite), .pcen(d8_pcen),
        .instr_done(d8_instr_done), .illegal(d8_illegal)
    );

    mips_mc_controller #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst32), .op(op), .zero(zero), .memready(memready),
        .memread(d32_memread), .memwrite(d32_memwrite), .alusrca(d32_alusrca),
        .alusrcb(d32_alusrcb), .aluop(d32_aluop), .pcsource(d32_pcsource),
        .iord(d32_iord), .memtoreg(d32_memtoreg), .regwrite(d32_regwrite),
        .regdst(d32_regdst), .irwrite(d32_irwrite), .pcen(d32_pcen),
        .instr_done(d32_instr_done), .illegal(d32_illegal)
    );

    assign o8  = {d8_memread, d8_memwrite, d8_alusrca, d8_alusrcb, d8_aluop, d8_pcsource,
                  d8_iord, d8_memtoreg, d8_regwrite, d8_regdst, d8_irwrite,
                  d8_pcen, d8_instr_done, d8_illegal};
    assign o32 = {d32_memread, d32_memwrite, d32_alusrca, d32_alusrcb, d32_aluop, d32_pcsource,
                  d32_iord, d32_memtoreg, d32_regwrite, d32_regdst, {3'b000, d32_irwrite},
                  d32_pcen, d32_instr_done, d32_illegal};

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int sel;        // 0 = WIDTH 8 instance, 1 = WIDTH 32 instance
    int beats;
    int fw[4];      // wait cycles before each fetch beat
    int mw;         // wait cycles in the data-memory phase
    int ncyc;
    int pcen_seen;

`ifdef MIPS_ADDI_EN
    localparam bit ADDI_ON = 1'b1;
`else
    localparam bit ADDI_ON = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic rbit();
        return 1'($urandom);
    endfunction

    function automatic logic [5:0] rop();
        return 6'($urandom);
    endfunction

    function automatic bit legal(input logic [5:0] c);
        return (c == OP_R) || (c == OP_LW) || (c == OP_SW) || (c == OP_BEQ) ||
               (c == OP_J) || (ADDI_ON && c == OP_ADDI);
    endfunction

    // Expected output vectors per phase, straight from the opcode rules.
    function automatic out_t e_fetch(input int k, input logic rdy);
        out_t e = '0;
        e.memread = 1'b1; e.alusrcb = 2'b01;
        if (rdy) begin e.irwrite = 4'(1 << k); e.pcen = 1'b1; end
        return e;
    endfunction
    function automatic out_t e_decode(input logic bad);
        out_t e = '0;
        e.alusrcb = 2'b11; e.illegal = bad; e.instr_done = bad;
        return e;
    endfunction
    function automatic out_t e_exec_imm();
        out_t e = '0;
        e.alusrca = 1'b1; e.alusrcb = 2'b10;
        return e;
    endfunction
    function automatic out_t e_lwrd();
        out_t e = '0;
        e.memread = 1'b1; e.iord = 1'b1;
        return e;
    endfunction
    function automatic out_t e_lwwr();
        out_t e = '0;
        e.regwrite = 1'b1; e.memtoreg = 1'b1; e.instr_done = 1'b1;
        return e;
    endfunction
    function automatic out_t e_swwr(input logic rdy);
        out_t e = '0;
        e.memwrite = 1'b1; e.iord = 1'b1; e.instr_done = rdy;
        return e;
    endfunction
    function automatic out_t e_rtex();
        out_t e = '0;
        e.alusrca = 1'b1; e.aluop = 2'b10;
        return e;
    endfunction
    function automatic out_t e_wr(input logic dst);
        out_t e = '0;
        e.regwrite = 1'b1; e.regdst = dst; e.instr_done = 1'b1;
        return e;
    endfunction
    function automatic out_t e_beq(input logic z);
        out_t e = '0;
        e.alusrca = 1'b1; e.aluop = 2'b01; e.pcsource = 2'b01;
        e.pcen = z; e.instr_done = 1'b1;
        return e;
    endfunction
    function automatic out_t e_jex();
        out_t e = '0;
        e.pcsource = 2'b10; e.pcen = 1'b1; e.instr_done = 1'b1;
        return e;
    endfunction

    // One clock: drive inputs just after the rising edge, compare at the falling edge.
    task automatic step(input out_t e, input logic rdy, input logic [5:0] op_v,
                        input logic z, input string tag);
        out_t got;
        memready = rdy; op = op_v; zero = z;
        @(negedge clk);
        got = (sel == 0) ? o8 : o32;
        if (got.pcen) pcen_seen++;
        check(tag, 32'(got), 32'(e));
        @(posedge clk);
        #1;
        ncyc++;
    endtask

    task automatic do_fetch(input int from);
        for (int k = from; k < beats; k++) begin
            repeat (fw[k]) step(e_fetch(k, 1'b0), 1'b0, rop(), rbit(), "fetch_wait");
            step(e_fetch(k, 1'b1), 1'b1, rop(), rbit(), "fetch_beat");
        end
    endtask

    task automatic finish_instr(input logic [5:0] c, input logic z);
        if (!legal(c)) begin
            step(e_decode(1'b1), rbit(), c, rbit(), "decode_illegal");
            return;
        end
        step(e_decode(1'b0), rbit(), c, rbit(), "decode");
        if (c == OP_LW) begin
            step(e_exec_imm(), rbit(), c, rbit(), "memadr_lw");
            repeat (mw) step(e_lwrd(), 1'b0, rop(), rbit(), "lwrd_wait");
            step(e_lwrd(), 1'b1, rop(), rbit(), "lwrd");
            step(e_lwwr(), rbit(), rop(), rbit(), "lwwr");
        end else if (c == OP_SW) begin
            step(e_exec_imm(), rbit(), c, rbit(), "memadr_sw");
            repeat (mw) step(e_swwr(1'b0), 1'b0, rop(), rbit(), "swwr_wait");
            step(e_swwr(1'b1), 1'b1, rop(), rbit(), "swwr");
        end else if (c == OP_R) begin
            step(e_rtex(), rbit(), rop(), rbit(), "rtex");
            step(e_wr(1'b1), rbit(), rop(), rbit(), "rtwr");
        end else if (c == OP_BEQ) begin
            step(e_beq(z), rbit(), rop(), z, "beqex");
        end else if (c == OP_J) begin
            step(e_jex(), rbit(), rop(), rbit(), "jex");
        end else begin
            step(e_exec_imm(), rbit(), rop(), rbit(), "addiex");
            step(e_wr(1'b0), rbit(), rop(), rbit(), "addiwr");
        end
    endtask

    task automatic run_instr(input logic [5:0] c, input logic z);
        ncyc = 0;
        pcen_seen = 0;
        do_fetch(0);
        finish_instr(c, z);
    endtask

    task automatic no_waits();
        for (int k = 0; k < 4; k++) fw[k] = 0;
        mw = 0;
    endtask

    task automatic rand_waits(input int maxw);
        for (int k = 0; k < 4; k++) fw[k] = $urandom_range(0, maxw);
        mw = $urandom_range(0, maxw);
    endtask

    function automatic logic [5:0] pick_op();
        case ($urandom_range(0, 6))
            0:       return OP_R;
            1:       return OP_LW;
            2:       return OP_SW;
            3:       return OP_BEQ;
            4:       return OP_J;
            5:       return OP_ADDI;
            default: return rop();
        endcase
    endfunction

    initial begin
        sel = 0; beats = 4;
        rst8 = 1'b1; rst32 = 1'b1;
        memready = 1'b0; op = '0; zero = 1'b0;

        // Reset: all outputs low regardless of inputs.
        repeat (3) step('0, rbit(), rop(), rbit(), "reset8");
        rst8 = 1'b0;

        // R-type, zero wait.
        no_waits();
        run_instr(OP_R, 1'b0);
        check("lat_rtype", ncyc, beats + 3);
        check("pcen_cnt_rtype", pcen_seen, beats);

        // LW with two waits before beat 1 and three in LWRD.
        no_waits(); fw[1] = 2; mw = 3;
        run_instr(OP_LW, 1'b0);
        check("lat_lw_waits", ncyc, 13);

        // Zero-wait latencies of the remaining classes.
        no_waits();
        run_instr(OP_LW, 1'b0);
        check("lat_lw", ncyc, beats + 4);
        run_instr(OP_SW, 1'b0);
        check("lat_sw", ncyc, beats + 3);
        run_instr(OP_BEQ, 1'b1);
        check("lat_beq_taken", ncyc, beats + 2);
        check("pcen_cnt_beq_taken", pcen_seen, beats + 1);
        run_instr(OP_BEQ, 1'b0);
        check("lat_beq_not_taken", ncyc, beats + 2);
        check("pcen_cnt_beq_not_taken", pcen_seen, beats);
        run_instr(OP_J, 1'b0);
        check("lat_j", ncyc, beats + 2);
        run_instr(6'b111111, 1'b0);
        check("lat_illegal", ncyc, beats + 1);
        run_instr(OP_ADDI, 1'b0);
        check("lat_addi", ncyc, ADDI_ON ? beats + 3 : beats + 1);

        // Reset during an LWRD wait, then a clean fetch from beat 0.
        no_waits();
        do_fetch(0);
        step(e_decode(1'b0), rbit(), OP_LW, rbit(), "decode_pre_rst");
        step(e_exec_imm(), rbit(), OP_LW, rbit(), "memadr_pre_rst");
        repeat (2) step(e_lwrd(), 1'b0, rop(), rbit(), "lwrd_wait_pre_rst");
        rst8 = 1'b1;
        repeat (2) step('0, rbit(), rop(), rbit(), "reset_mid_lwrd");
        rst8 = 1'b0;
        step(e_fetch(0, 1'b0), 1'b0, rop(), rbit(), "post_rst_wait");
        step(e_fetch(0, 1'b1), 1'b1, rop(), rbit(), "post_rst_beat0");
        do_fetch(1);
        finish_instr(OP_J, 1'b0);

        // Random instruction stream with random waits.
        for (int i = 0; i < 40; i++) begin
            rand_waits(2);
            run_instr(pick_op(), rbit());
        end

        // WIDTH=32 instance: one-beat fetch.
        rst8 = 1'b1;
        sel = 1; beats = 1;
        step('0, rbit(), rop(), rbit(), "reset32");
        rst32 = 1'b0;
        no_waits();
        run_instr(OP_SW, 1'b0);
        check("lat_sw_w32", ncyc, 4);
        run_instr(OP_LW, 1'b0);
        check("lat_lw_w32", ncyc, 5);
        for (int i = 0; i < 15; i++) begin
            rand_waits(2);
            run_instr(pick_op(), rbit());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
